// File: rtl/dcache2frame_pkg.sv
// Shared definitions for the Dcache2Frame read-side scheduler.
package dcache2frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PAD     = 3'd4,
    ST_CSUM    = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] PAD_BYTE_DEF  = 8'h00;

  // Trailer byte that makes SEQ + body + trailer sum to zero mod 256.
  function automatic logic [7:0] csum_tail(input logic [7:0] acc);
    return (~acc) + 8'd1;
  endfunction

endpackage

// File: rtl/dcache2frame_rd_sched.sv
// Drains the show-ahead FIFO into SYNC/SEQ/payload/CSUM frames on a valid/ready
// byte stream, padding the remainder of a frame after a sustained underflow.
module dcache2frame_rd_sched
  import dcache2frame_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned LEN_W     = 16,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic [7:0]  PAD_BYTE  = PAD_BYTE_DEF,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        rd_clk,
  input  logic        rd_rst_n,
  input  logic        enable,
  input  logic        clr_status,
  input  logic        fifo_rd_vld,
  input  logic [7:0]  fifo_rd_data,
  output logic        fifo_rd_en,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_last,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        underrun
);

  localparam int unsigned STALL_W = $clog2(TIMEOUT);
  localparam logic [LEN_W-1:0]   LAST_IDX  = LEN_W'(FRAME_LEN - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [7:0]         seq_q, seq_d;
  logic [7:0]         csum_q, csum_d;
  logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               underrun_q, underrun_d;
  logic               xfer_s;

  // Stream and FIFO handshake outputs decoded from the current state.
  always_comb begin
    out_data   = 8'h00;
    out_valid  = 1'b0;
    out_sof    = 1'b0;
    out_last   = 1'b0;
    fifo_rd_en = 1'b0;
    case (state_q)
      ST_HDR0: begin
        out_data  = SYNC_BYTE;
        out_valid = 1'b1;
        out_sof   = 1'b1;
      end
      ST_HDR1: begin
        out_data  = seq_q;
        out_valid = 1'b1;
      end
      ST_PAYLOAD: begin
        out_data   = fifo_rd_data;
        out_valid  = fifo_rd_vld;
        fifo_rd_en = fifo_rd_vld && out_ready;
      end
      ST_PAD: begin
        out_data  = PAD_BYTE;
        out_valid = 1'b1;
      end
      ST_CSUM: begin
        out_data  = csum_tail(csum_q);
        out_valid = 1'b1;
        out_last  = 1'b1;
      end
      default: begin
        out_data = 8'h00;
      end
    endcase
  end

  assign xfer_s = out_valid && out_ready;

  // Next-state, counters, checksum and sticky status.
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    csum_d      = csum_q;
    byte_cnt_d  = byte_cnt_q;
    stall_cnt_d = stall_cnt_q;
    frame_cnt_d = frame_cnt_q;
    underrun_d  = clr_status ? 1'b0 : underrun_q;
    case (state_q)
      ST_IDLE: begin
        csum_d      = 8'h00;
        byte_cnt_d  = '0;
        stall_cnt_d = '0;
        if (enable && fifo_rd_vld) state_d = ST_HDR0;
      end
      ST_HDR0: begin
        if (xfer_s) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        if (xfer_s) begin
          csum_d  = csum_q + seq_q;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (xfer_s) begin
          csum_d      = csum_q + fifo_rd_data;
          byte_cnt_d  = byte_cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
          stall_cnt_d = '0;
          if (byte_cnt_q == LAST_IDX) state_d = ST_CSUM;
        end else if (!fifo_rd_vld) begin
          stall_cnt_d = stall_cnt_q + {{(STALL_W-1){1'b0}}, 1'b1};
          // A set in the same cycle as clr_status overrides the clear.
          if (stall_cnt_d == STALL_MAX) begin
            underrun_d = 1'b1;
            state_d    = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (xfer_s) begin
          csum_d     = csum_q + PAD_BYTE;
          byte_cnt_d = byte_cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
          if (byte_cnt_q == LAST_IDX) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (xfer_s) begin
          seq_d       = seq_q + 8'd1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q     <= ST_IDLE;
      seq_q       <= 8'h00;
      csum_q      <= 8'h00;
      byte_cnt_q  <= '0;
      stall_cnt_q <= '0;
      frame_cnt_q <= 16'h0000;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      csum_q      <= csum_d;
      byte_cnt_q  <= byte_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      underrun_q  <= underrun_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign frame_cnt = frame_cnt_q;
  assign underrun  = underrun_q;

endmodule
